// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result bundle for the bit-serial subtractor.
//   start      - request a new subtraction (master -> slave)
//   a, b       - minuend and subtrahend, WIDTH bits (master -> slave)
//   bin        - borrow-in, only when SERIAL_SUB_BIN_EN is defined (master -> slave)
//   busy, done - operation in progress / one-cycle completion pulse (slave -> master)
//   diff, bout - result and final borrow-out (slave -> master)
// Optional feature macro: SERIAL_SUB_BIN_EN.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_BIN_EN
  logic             bin;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

`ifdef SERIAL_SUB_BIN_EN
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`else
  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, a - b (- bin), LSB first,
// one full-subtractor cell with a registered borrow. WIDTH run cycles per operation.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - serial_subtractor_if.slave (start/a/b[/bin] in, busy/done/diff/bout out)
// Optional feature macro: SERIAL_SUB_BIN_EN (adds bin as the initial borrow).
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic              bout_q, bout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic x, y, w, d, bo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    x  = a_q[0];
    y  = b_q[0];
    w  = borrow_q;
    d  = x ^ y ^ w;
    bo = (~x & y) | (~(x ^ y) & w);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
`ifdef SERIAL_SUB_BIN_EN
          borrow_d = bus.bin;
`else
          borrow_d = 1'b0;
`endif
          cnt_d    = '0;
          state_d  = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        diff_d   = {d, diff_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = bo;
        // Last bit is processed with the counter at WIDTH-1; hold it there so it never wraps.
        if (cnt_q == CntW'(WIDTH - 1)) begin
          bout_d  = bo;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) sif ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bi);
    logic [W:0] r;
    exp_t       e;
    r      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    e.diff = r[W-1:0];
    e.bout = r[W];
    return e;
  endfunction

  task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bi);
    sif.start = st;
    sif.a     = a;
    sif.b     = b;
`ifdef SERIAL_SUB_BIN_EN
    sif.bin   = bi;
`else
    if (bi) $display("note: bin ignored without SERIAL_SUB_BIN_EN");
`endif
  endtask

  // busy and done must never be high together.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ((sif.busy && sif.done) !== 1'b0) begin
        bad++;
        $display("FAIL busy_done_excl: busy=%b done=%b required not both 1", sif.busy, sif.done);
      end
    end
  end

  // Start one op from idle, wait for done, check against the scoreboard.
  // inj >= 0: pulse a spurious start (0xFF - 0x00) at that busy cycle index.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input int inj);
    int   lat;
    int   nbusy;
    bit   seen;
    exp_t e;
    drive(1'b1, a, b, bi);
    sb.push_back(model(a, b, bi));
    @(negedge clk);
    drive(1'b0, a, b, 1'b0);
    lat   = 0;
    nbusy = 0;
    seen  = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sif.done) begin
        seen = 1;
      end else begin
        if (sif.busy) nbusy++;
        if (lat == inj) drive(1'b1, 8'hFF, 8'h00, 1'b0);
        else if (lat == inj + 1) drive(1'b0, 8'hFF, 8'h00, 1'b0);
        @(negedge clk);
        lat++;
      end
    end
    sif.start = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: done not seen within 20 cycles", name);
      return;
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_sb: done with empty scoreboard", name);
      return;
    end
    e = sb.pop_front();
    total++;
    if (sif.diff !== e.diff) begin
      bad++;
      $display("FAIL %s_diff: got %h required %h", name, sif.diff, e.diff);
    end
    total++;
    if (sif.bout !== e.bout) begin
      bad++;
      $display("FAIL %s_bout: got %b required %b", name, sif.bout, e.bout);
    end
    total++;
    if (lat !== W) begin
      bad++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, W);
    end
    total++;
    if (nbusy !== W) begin
      bad++;
      $display("FAIL %s_busy_cycles: got %0d required %0d", name, nbusy, W);
    end
    @(negedge clk);
    total++;
    if (sif.done !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_pulse: done=%b one cycle later, required 0", name, sif.done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if ({sif.busy, sif.done, sif.diff, sif.bout} !== '0) begin
      bad++;
      $display("FAIL reset_values: busy=%b done=%b diff=%h bout=%b required all 0",
               sif.busy, sif.done, sif.diff, sif.bout);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op("basic", 8'h35, 8'h12, 1'b0, -1);
  endtask

  task automatic test_negative();
    run_op("neg_12_35", 8'h12, 8'h35, 1'b0, -1);
    run_op("neg_00_01", 8'h00, 8'h01, 1'b0, -1);
    run_op("wrap_ff_ff", 8'hFF, 8'hFF, 1'b0, -1);
  endtask

  task automatic test_ignored_start();
    int extra;
    run_op("ignored", 8'h35, 8'h12, 1'b0, 2);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      if (sif.done) extra++;
      @(negedge clk);
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL ignored_extra_done: got %0d pulses required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int   ndone;
    int   t0;
    int   t1;
    bit   drop;
    exp_t e;
    drive(1'b1, 8'h80, 8'h01, 1'b0);
    sb.push_back(model(8'h80, 8'h01, 1'b0));
    sb.push_back(model(8'h01, 8'h01, 1'b0));
    @(negedge clk);
    drive(1'b1, 8'h01, 8'h01, 1'b0);
    ndone = 0;
    t0    = 0;
    t1    = 0;
    drop  = 0;
    for (int i = 1; i < 40 && ndone < 2; i++) begin
      if (drop) begin
        sif.start = 1'b0;
        drop = 0;
      end
      if (sif.done) begin
        if (ndone == 0) begin
          t0   = i;
          drop = 1;
        end else begin
          t1 = i;
        end
        ndone++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL b2b_sb: done with empty scoreboard");
        end else begin
          e = sb.pop_front();
          total++;
          if ({sif.diff, sif.bout} !== {e.diff, e.bout}) begin
            bad++;
            $display("FAIL b2b_result%0d: got %h/%b required %h/%b", ndone, sif.diff,
                     sif.bout, e.diff, e.bout);
          end
        end
      end
      @(negedge clk);
    end
    sif.start = 1'b0;
    total++;
    if (ndone !== 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d done pulses required 2", ndone);
    end
    total++;
    if (t1 - t0 !== W + 1) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d cycles required %0d", t1 - t0, W + 1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ndone;
    drive(1'b1, 8'h35, 8'h12, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h35, 8'h12, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({sif.busy, sif.done, sif.diff, sif.bout} !== '0) begin
      bad++;
      $display("FAIL reset_mid_values: busy=%b done=%b diff=%h bout=%b required all 0",
               sif.busy, sif.done, sif.diff, sif.bout);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (sif.done) ndone++;
      @(negedge clk);
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL reset_mid_no_done: got %0d pulses required 0", ndone);
    end
    run_op("after_reset", 8'h10, 8'h01, 1'b0, -1);
  endtask

`ifdef SERIAL_SUB_BIN_EN
  task automatic test_bin();
    run_op("bin_10_0f", 8'h10, 8'h0F, 1'b1, -1);
    run_op("bin_00_00", 8'h00, 8'h00, 1'b1, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_SUB_BIN_EN
    test_bin();
`endif
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_drain: %0d entries left required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
